// File: rtl/busctrl_pipe_pkg.sv
// Shared definitions for the registered bus controller: FSM state encodings, error cause
// codes and the default memory map.
package busctrl_pipe_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2,
        StErr    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CauseNone     = 2'b00,
        CauseUnmapped = 2'b01,
        CauseTimeout  = 2'b10
    } cause_e;

    localparam int unsigned DefNslv   = 4;
    localparam int unsigned DefTmoCyc = 256;

    localparam logic [127:0] DefSlvBase = {32'h30100000, 32'h30000000, 32'h20000000, 32'h00000000};
    localparam logic [127:0] DefSlvMask = {32'hFFF00000, 32'hFFF00000, 32'hFF000000, 32'hFC000000};

    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/busctrl_dec.sv
// Combinational address decoder: one-hot hit vector, lowest slave index wins on overlap,
// plus a miss flag when no window matches.
module busctrl_dec
    import busctrl_pipe_pkg::*;
#(
    parameter int unsigned          NSLV     = DefNslv,
    parameter logic [NSLV*32-1:0]   SLV_BASE = DefSlvBase,
    parameter logic [NSLV*32-1:0]   SLV_MASK = DefSlvMask
) (
    input  logic [31:0]     addr,
    output logic [NSLV-1:0] hit,
    output logic            miss
);

    logic found;

    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (!found && addr_hit(addr, SLV_BASE[32*i +: 32], SLV_MASK[32*i +: 32])) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
        miss = ~found;
    end

endmodule

// File: rtl/busctrl_pipe.sv
// Registered CPU-to-slave bus controller with per-access watchdog.
// Optional error capture registers are built when BUSCTRL_ERR_CAPTURE_EN is defined.
module busctrl_pipe
    import busctrl_pipe_pkg::*;
#(
    parameter int unsigned          NSLV     = DefNslv,
    parameter logic [NSLV*32-1:0]   SLV_BASE = DefSlvBase,
    parameter logic [NSLV*32-1:0]   SLV_MASK = DefSlvMask,
    parameter int unsigned          TMO_CYC  = DefTmoCyc
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_en,
    input  logic                cpu_wr,
    input  logic [1:0]          cpu_size,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_data_out,
    output logic [31:0]         cpu_data_in,
    output logic                cpu_wt,
    output logic                cpu_err,
    output logic [NSLV-1:0]     slv_en,
    output logic                slv_wr,
    output logic [1:0]          slv_size,
    output logic [31:0]         slv_addr,
    output logic [31:0]         slv_data_in,
    input  logic [NSLV*32-1:0]  slv_data_out,
    input  logic [NSLV-1:0]     slv_wt
`ifdef BUSCTRL_ERR_CAPTURE_EN
    ,
    input  logic                err_clr,
    output logic [31:0]         err_addr,
    output logic [1:0]          err_cause
`endif
);

    localparam int unsigned     CntW    = $clog2(TMO_CYC);
    localparam logic [CntW-1:0] TmoLast = CntW'(TMO_CYC - 1);

    state_e          state_q, state_d;
    logic [NSLV-1:0] slv_en_q, slv_en_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [NSLV-1:0] dec_hit;
    logic            dec_miss;
    logic [31:0]     rd_mux;
    logic            sel_wt;

    busctrl_dec #(
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (cpu_addr),
        .hit  (dec_hit),
        .miss (dec_miss)
    );

    // slv_en_q doubles as the latched one-hot select while in ACCESS.
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (slv_en_q[i]) begin
                rd_mux = rd_mux | slv_data_out[32*i +: 32];
            end
        end
        sel_wt = |(slv_wt & slv_en_q);
    end

    always_comb begin
        state_d  = state_q;
        slv_en_d = slv_en_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle: begin
                if (cpu_en) begin
                    if (!dec_miss) begin
                        wr_d     = cpu_wr;
                        size_d   = cpu_size;
                        addr_d   = cpu_addr;
                        wdata_d  = cpu_data_out;
                        slv_en_d = dec_hit;
                        cnt_d    = '0;
                        state_d  = StAccess;
                    end else begin
                        rdata_d = '0;
                        state_d = StErr;
                    end
                end
            end
            StAccess: begin
                if (!cpu_en) begin
                    slv_en_d = '0;
                    state_d  = StIdle;
                end else if (!sel_wt) begin
                    // Completion is checked before the watchdog so it wins a tie.
                    rdata_d  = wr_q ? 32'h0 : rd_mux;
                    slv_en_d = '0;
                    state_d  = StDone;
                end else if (cnt_q == TmoLast) begin
                    rdata_d  = '0;
                    slv_en_d = '0;
                    state_d  = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                slv_en_d = '0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            slv_en_q <= '0;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            slv_en_q <= slv_en_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cpu_wt      = !((state_q == StDone) || (state_q == StErr));
    assign cpu_err     = (state_q == StErr);
    assign cpu_data_in = rdata_q;
    assign slv_en      = slv_en_q;
    assign slv_wr      = wr_q;
    assign slv_size    = size_q;
    assign slv_addr    = addr_q;
    assign slv_data_in = wdata_q;

`ifdef BUSCTRL_ERR_CAPTURE_EN
    logic        err_event;
    cause_e      new_cause;
    logic [31:0] new_addr;
    cause_e      err_cause_q;
    logic [31:0] err_addr_q;

    // Entry to ERR from IDLE is always an unmapped access; from ACCESS a timeout.
    assign err_event = (state_d == StErr) && (state_q != StErr);
    assign new_cause = (state_q == StIdle) ? CauseUnmapped : CauseTimeout;
    assign new_addr  = (state_q == StIdle) ? cpu_addr : addr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_cause_q <= CauseNone;
            err_addr_q  <= '0;
        end else if (err_event && ((err_cause_q == CauseNone) || err_clr)) begin
            err_cause_q <= new_cause;
            err_addr_q  <= new_addr;
        end else if (err_clr) begin
            err_cause_q <= CauseNone;
            err_addr_q  <= '0;
        end
    end

    assign err_cause = err_cause_q;
    assign err_addr  = err_addr_q;
`endif

endmodule

// File: tb/tb_busctrl_pipe.sv
// Directed self-checking bench for busctrl_pipe with the default four-slave memory map.
module tb_busctrl_pipe;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cpu_en;
    logic         cpu_wr;
    logic [1:0]   cpu_size;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_data_out;
    logic [31:0]  cpu_data_in;
    logic         cpu_wt;
    logic         cpu_err;
    logic [3:0]   slv_en;
    logic         slv_wr;
    logic [1:0]   slv_size;
    logic [31:0]  slv_addr;
    logic [31:0]  slv_data_in;
    logic [127:0] slv_data_out;
    logic [3:0]   slv_wt;
`ifdef BUSCTRL_ERR_CAPTURE_EN
    logic         err_clr;
    logic [31:0]  err_addr;
    logic [1:0]   err_cause;
`endif

    int errors = 0;
    int checks = 0;

    busctrl_pipe dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_en       (cpu_en),
        .cpu_wr       (cpu_wr),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_in  (cpu_data_in),
        .cpu_wt       (cpu_wt),
        .cpu_err      (cpu_err),
        .slv_en       (slv_en),
        .slv_wr       (slv_wr),
        .slv_size     (slv_size),
        .slv_addr     (slv_addr),
        .slv_data_in  (slv_data_in),
        .slv_data_out (slv_data_out),
        .slv_wt       (slv_wt)
`ifdef BUSCTRL_ERR_CAPTURE_EN
        ,
        .err_clr      (err_clr),
        .err_addr     (err_addr),
        .err_cause    (err_cause)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_en       = 1'b1;
        cpu_wr       = wr;
        cpu_size     = 2'b10;
        cpu_addr     = addr;
        cpu_data_out = wdata;
    endtask

    task automatic finish_access();
        cpu_en = 1'b0;
        slv_wt = 4'b1111;
        tick();
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        cpu_en       = 1'b0;
        cpu_wr       = 1'b0;
        cpu_size     = 2'b00;
        cpu_addr     = '0;
        cpu_data_out = '0;
        slv_data_out = '0;
        slv_wt       = 4'b1111;
`ifdef BUSCTRL_ERR_CAPTURE_EN
        err_clr      = 1'b0;
`endif
        tick();
        tick();
        if (cpu_wt !== 1'b1) begin errors++; $display("FAIL rst_wt got=%0h exp=1", cpu_wt); end
        checks++;
        if (cpu_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", cpu_err); end
        checks++;
        if (slv_en !== 4'b0) begin errors++; $display("FAIL rst_en got=%b exp=0000", slv_en); end
        checks++;
        if (cpu_data_in !== 32'h0) begin
            errors++; $display("FAIL rst_rdata got=%h exp=0", cpu_data_in);
        end
        checks++;
        if ({slv_wr, slv_size, slv_addr, slv_data_in} !== 67'h0) begin
            errors++; $display("FAIL rst_latch got=%h exp=0", {slv_wr, slv_size, slv_addr, slv_data_in});
        end
        checks++;
`ifdef BUSCTRL_ERR_CAPTURE_EN
        if ({err_addr, err_cause} !== 34'h0) begin
            errors++; $display("FAIL rst_errcap got=%h exp=0", {err_addr, err_cause});
        end
        checks++;
`endif
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        start(1'b0, 32'h00000010, 32'h0);
        slv_wt = 4'b1110;
        slv_data_out[31:0] = 32'hDEADBEEF;
        tick();
        if (slv_en !== 4'b0001 || cpu_wt !== 1'b1) begin
            errors++; $display("FAIL rd_access got en=%b wt=%0h exp en=0001 wt=1", slv_en, cpu_wt);
        end
        checks++;
        tick();
        if (cpu_wt !== 1'b0 || cpu_err !== 1'b0 || cpu_data_in !== 32'hDEADBEEF || slv_en !== 4'b0) begin
            errors++;
            $display("FAIL rd_done got wt=%0h err=%0h data=%h en=%b exp wt=0 err=0 data=deadbeef en=0000",
                     cpu_wt, cpu_err, cpu_data_in, slv_en);
        end
        checks++;
        finish_access();
        if (cpu_wt !== 1'b1) begin errors++; $display("FAIL rd_idle got wt=%0h exp=1", cpu_wt); end
        checks++;
    endtask

    task automatic test_unmapped();
        start(1'b0, 32'h40000000, 32'h0);
        tick();
        if (cpu_wt !== 1'b0 || cpu_err !== 1'b1 || cpu_data_in !== 32'h0 || slv_en !== 4'b0) begin
            errors++;
            $display("FAIL unmap got wt=%0h err=%0h data=%h en=%b exp wt=0 err=1 data=0 en=0000",
                     cpu_wt, cpu_err, cpu_data_in, slv_en);
        end
        checks++;
`ifdef BUSCTRL_ERR_CAPTURE_EN
        if (err_addr !== 32'h40000000 || err_cause !== 2'b01) begin
            errors++; $display("FAIL unmap_cap got addr=%h cause=%b exp 40000000/01", err_addr, err_cause);
        end
        checks++;
`endif
        finish_access();
        if (cpu_wt !== 1'b1 || cpu_err !== 1'b0) begin
            errors++; $display("FAIL unmap_idle got wt=%0h err=%0h exp 1/0", cpu_wt, cpu_err);
        end
        checks++;
    endtask

    task automatic test_write_wait();
        start(1'b1, 32'h30000004, 32'h00000055);
        slv_wt = 4'b1111;
        slv_data_out[95:64] = 32'hA5A5A5A5;
        tick();
        if (slv_en !== 4'b0100 || slv_data_in !== 32'h55 || slv_wr !== 1'b1 || slv_addr !== 32'h30000004) begin
            errors++;
            $display("FAIL wr_access got en=%b wdata=%h wr=%0h addr=%h exp 0100/55/1/30000004",
                     slv_en, slv_data_in, slv_wr, slv_addr);
        end
        checks++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_wt !== 1'b1 || slv_en !== 4'b0100) begin
                errors++; $display("FAIL wr_wait%0d got wt=%0h en=%b exp 1/0100", i, cpu_wt, slv_en);
            end
            checks++;
        end
        slv_wt = 4'b1011;
        tick();
        if (cpu_wt !== 1'b0 || cpu_err !== 1'b0 || cpu_data_in !== 32'h0 || slv_en !== 4'b0) begin
            errors++;
            $display("FAIL wr_done got wt=%0h err=%0h data=%h en=%b exp 0/0/0/0000",
                     cpu_wt, cpu_err, cpu_data_in, slv_en);
        end
        checks++;
        finish_access();
    endtask

    task automatic test_timeout();
        start(1'b0, 32'h20000100, 32'h0);
        slv_wt = 4'b1111;
        slv_data_out[63:32] = 32'hCAFEF00D;
        tick();
        if (slv_en !== 4'b0010) begin errors++; $display("FAIL tmo_en got=%b exp=0010", slv_en); end
        checks++;
        repeat (255) tick();
        if (cpu_wt !== 1'b1 || slv_en !== 4'b0010) begin
            errors++; $display("FAIL tmo_early got wt=%0h en=%b exp 1/0010", cpu_wt, slv_en);
        end
        checks++;
        tick();
        if (cpu_wt !== 1'b0 || cpu_err !== 1'b1 || slv_en !== 4'b0 || cpu_data_in !== 32'h0) begin
            errors++;
            $display("FAIL tmo_err got wt=%0h err=%0h en=%b data=%h exp 0/1/0000/0",
                     cpu_wt, cpu_err, slv_en, cpu_data_in);
        end
        checks++;
        finish_access();
        // Same access, slave releases in the last allowed cycle: completion must win.
        start(1'b0, 32'h20000100, 32'h0);
        tick();
        repeat (255) tick();
        slv_wt = 4'b1101;
        tick();
        if (cpu_wt !== 1'b0 || cpu_err !== 1'b0 || cpu_data_in !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL tmo_tie got wt=%0h err=%0h data=%h exp 0/0/cafef00d", cpu_wt, cpu_err, cpu_data_in);
        end
        checks++;
        finish_access();
    endtask

    task automatic test_reset_mid();
        start(1'b1, 32'h00000020, 32'h11111111);
        slv_wt = 4'b1111;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        if (slv_en !== 4'b0 || cpu_wt !== 1'b1 || slv_addr !== 32'h0 || cpu_data_in !== 32'h0) begin
            errors++;
            $display("FAIL rstmid got en=%b wt=%0h addr=%h data=%h exp 0000/1/0/0",
                     slv_en, cpu_wt, slv_addr, cpu_data_in);
        end
        checks++;
        reset_n = 1'b1;
        cpu_en  = 1'b0;
        tick();
        if (slv_en !== 4'b0 || cpu_wt !== 1'b1) begin
            errors++; $display("FAIL rstmid_idle got en=%b wt=%0h exp 0000/1", slv_en, cpu_wt);
        end
        checks++;
    endtask

    task automatic test_abort();
        start(1'b0, 32'h00000040, 32'h0);
        slv_wt = 4'b1111;
        tick();
        cpu_en = 1'b0;
        slv_wt = 4'b1110;
        tick();
        if (slv_en !== 4'b0 || cpu_wt !== 1'b1) begin
            errors++; $display("FAIL abort got en=%b wt=%0h exp 0000/1", slv_en, cpu_wt);
        end
        checks++;
        tick();
        if (cpu_wt !== 1'b1 || cpu_err !== 1'b0) begin
            errors++; $display("FAIL abort_nopulse got wt=%0h err=%0h exp 1/0", cpu_wt, cpu_err);
        end
        checks++;
        start(1'b0, 32'h00000010, 32'h0);
        tick();
        if (slv_en !== 4'b0001) begin errors++; $display("FAIL abort_next got=%b exp=0001", slv_en); end
        checks++;
        tick();
        finish_access();
    endtask

    task automatic test_back_to_back();
        start(1'b0, 32'h00000010, 32'h0);
        slv_wt = 4'b0000;
        slv_data_out[31:0]   = 32'h0BADF00D;
        slv_data_out[127:96] = 32'h12345678;
        tick();
        tick();
        if (cpu_wt !== 1'b0 || cpu_data_in !== 32'h0BADF00D) begin
            errors++; $display("FAIL b2b_first got wt=%0h data=%h exp 0/0badf00d", cpu_wt, cpu_data_in);
        end
        checks++;
        cpu_addr = 32'h30100008;
        tick();
        if (slv_en !== 4'b0 || cpu_wt !== 1'b1) begin
            errors++; $display("FAIL b2b_gap got en=%b wt=%0h exp 0000/1", slv_en, cpu_wt);
        end
        checks++;
        tick();
        if (slv_en !== 4'b1000) begin errors++; $display("FAIL b2b_sel got=%b exp=1000", slv_en); end
        checks++;
        tick();
        if (cpu_wt !== 1'b0 || cpu_data_in !== 32'h12345678) begin
            errors++; $display("FAIL b2b_second got wt=%0h data=%h exp 0/12345678", cpu_wt, cpu_data_in);
        end
        checks++;
        finish_access();
    endtask

`ifdef BUSCTRL_ERR_CAPTURE_EN
    task automatic test_err_capture();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        if (err_addr !== 32'h0 || err_cause !== 2'b00) begin
            errors++; $display("FAIL cap_clr0 got addr=%h cause=%b exp 0/00", err_addr, err_cause);
        end
        checks++;
        start(1'b0, 32'h50000000, 32'h0);
        tick();
        cpu_addr = 32'h60000000;
        tick();
        tick();
        if (cpu_err !== 1'b1 || err_addr !== 32'h50000000 || err_cause !== 2'b01) begin
            errors++;
            $display("FAIL cap_sticky got err=%0h addr=%h cause=%b exp 1/50000000/01", cpu_err, err_addr, err_cause);
        end
        checks++;
        finish_access();
        err_clr = 1'b1;
        tick();
        if (err_addr !== 32'h0 || err_cause !== 2'b00) begin
            errors++; $display("FAIL cap_clr got addr=%h cause=%b exp 0/00", err_addr, err_cause);
        end
        checks++;
        start(1'b0, 32'h70000000, 32'h0);
        tick();
        err_clr = 1'b0;
        if (err_addr !== 32'h70000000 || err_cause !== 2'b01) begin
            errors++; $display("FAIL cap_clr_new got addr=%h cause=%b exp 70000000/01", err_addr, err_cause);
        end
        checks++;
        finish_access();
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_unmapped();
        test_write_wait();
        test_timeout();
        test_reset_mid();
        test_abort();
        test_back_to_back();
`ifdef BUSCTRL_ERR_CAPTURE_EN
        test_err_capture();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

endmodule
